// File: rtl/friscv_wb_arbiter_pkg.sv
// Write-back arbiter constants and round-robin index helper.
`include "friscv_h.sv"

package friscv_wb_arbiter_pkg;

    localparam int unsigned RD_W = `RD_W;

    // Single-step modulo: callers never pass idx >= 2*n.
    function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage

// File: rtl/friscv_h.sv
// Shared write-back definitions: register address width and write-back entry width.
`ifndef FRISCV_H
`define FRISCV_H

`define RD_W 5
`define WB_ENTRY_W(xlen) (`RD_W + (xlen) + (xlen) / 8)

`endif

// File: rtl/friscv_scfifo.sv
// Single-clock FIFO with full/empty flags, asynchronous and synchronous reset.
module friscv_scfifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             srst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o && !srst;
    assign do_pop  = pop_i && !empty_o && !srst;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/friscv_wb_arbiter.sv
// Round-robin write-back arbiter sharing one register-file write port between units.
// Define FRISCV_WB_OUTPUT_REG_EN to register the rd_* outputs (one extra cycle of latency).
`include "friscv_h.sv"

module friscv_wb_arbiter
    import friscv_wb_arbiter_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NB_UNIT    = 3,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      srst,
    input  logic [NB_UNIT-1:0]        req_valid,
    output logic [NB_UNIT-1:0]        req_ready,
    input  logic [NB_UNIT*5-1:0]      req_rd_addr,
    input  logic [NB_UNIT*XLEN-1:0]   req_rd_val,
    input  logic [NB_UNIT*XLEN/8-1:0] req_rd_strb,
    output logic                      rd_wr,
    output logic [4:0]                rd_addr,
    output logic [XLEN-1:0]           rd_val,
    output logic [XLEN/8-1:0]         rd_strb,
    output logic [NB_UNIT-1:0]        pending,
    output logic                      busy
);

    localparam int unsigned STRB_W  = XLEN / 8;
    localparam int unsigned ENTRY_W = `WB_ENTRY_W(XLEN);
    localparam int unsigned PTR_W   = $clog2(NB_UNIT);

    logic [NB_UNIT-1:0] fifo_full;
    logic [NB_UNIT-1:0] fifo_empty;
    logic [NB_UNIT-1:0] fifo_push;
    logic [NB_UNIT-1:0] fifo_pop;
    logic [ENTRY_W-1:0] fifo_head [NB_UNIT];

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               grant_vld;
    logic [PTR_W-1:0]   grant_idx;
    logic [ENTRY_W-1:0] grant_entry;
    logic [RD_W-1:0]    grant_addr;
    logic [XLEN-1:0]    grant_val;
    logic [STRB_W-1:0]  grant_strb;

    for (genvar i = 0; i < NB_UNIT; i++) begin : g_unit
        logic [RD_W-1:0] unit_addr;

        assign unit_addr    = req_rd_addr[i*RD_W +: RD_W];
        // Writes to x0 are acknowledged but never reach the buffer.
        assign fifo_push[i] = req_valid[i] && (unit_addr != '0);

        friscv_scfifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .aclk    (aclk),
            .aresetn (aresetn),
            .srst    (srst),
            .push_i  (fifo_push[i]),
            .data_i  ({unit_addr, req_rd_val[i*XLEN +: XLEN], req_rd_strb[i*STRB_W +: STRB_W]}),
            .pop_i   (fifo_pop[i]),
            .data_o  (fifo_head[i]),
            .full_o  (fifo_full[i]),
            .empty_o (fifo_empty[i])
        );
    end

    always_comb begin
        int unsigned idx;
        logic        found;
        idx       = 0;
        found     = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NB_UNIT; k++) begin
            idx = rr_wrap(32'(rr_ptr_q) + k, NB_UNIT);
            if (!found && !fifo_empty[PTR_W'(idx)]) begin
                found     = 1'b1;
                grant_idx = PTR_W'(idx);
            end
        end
        grant_vld = found && !srst;
    end

    always_comb begin
        fifo_pop = '0;
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) begin
            fifo_pop[grant_idx] = 1'b1;
            rr_ptr_d            = PTR_W'(rr_wrap(32'(grant_idx) + 32'd1, NB_UNIT));
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rr_ptr_q <= '0;
        end else if (srst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign grant_entry                          = fifo_head[grant_idx];
    assign {grant_addr, grant_val, grant_strb}  = grant_entry;

    assign req_ready = ~fifo_full | {NB_UNIT{srst}};
    assign pending   = srst ? '0 : ~fifo_empty;

`ifdef FRISCV_WB_OUTPUT_REG_EN
    logic              out_vld_q;
    logic [RD_W-1:0]   out_addr_q;
    logic [XLEN-1:0]   out_val_q;
    logic [STRB_W-1:0] out_strb_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_vld_q  <= 1'b0;
            out_addr_q <= '0;
            out_val_q  <= '0;
            out_strb_q <= '0;
        end else if (srst) begin
            out_vld_q  <= 1'b0;
            out_addr_q <= '0;
            out_val_q  <= '0;
            out_strb_q <= '0;
        end else begin
            out_vld_q <= grant_vld;
            if (grant_vld) begin
                out_addr_q <= grant_addr;
                out_val_q  <= grant_val;
                out_strb_q <= grant_strb;
            end
        end
    end

    // srst masks the stage immediately so reset values appear without waiting an edge.
    assign rd_wr   = out_vld_q && !srst;
    assign rd_addr = srst ? '0 : out_addr_q;
    assign rd_val  = srst ? '0 : out_val_q;
    assign rd_strb = srst ? '0 : out_strb_q;
    assign busy    = !srst && ((|(~fifo_empty)) || out_vld_q);
`else
    assign rd_wr   = grant_vld;
    assign rd_addr = grant_vld ? grant_addr : '0;
    assign rd_val  = grant_vld ? grant_val : '0;
    assign rd_strb = grant_vld ? grant_strb : '0;
    assign busy    = !srst && (|(~fifo_empty));
`endif

endmodule
